// File: rtl/au_sequencer.sv
// au_sequencer: fetches register-file operands for one micro-op, hands them to the
// sign-magnitude AU, waits for its done pulse and writes the result back.
// Optional watchdog on the WAIT state is built when AUSEQ_TIMEOUT_EN is defined.
module au_sequencer #(
    parameter int W       = 24,
    parameter int FRAC    = 14,
    parameter int NREG    = 16,
    parameter int TIMEOUT = 64,
    localparam int AW     = $clog2(NREG),
    localparam int IW     = 6 + 3 * AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_instr_valid,
    output logic          o_instr_ready,
    input  logic [IW-1:0] i_instr,
    input  logic          i_rf_we,
    input  logic [AW-1:0] i_rf_waddr,
    input  logic [W-1:0]  i_rf_wdata,
    input  logic [AW-1:0] i_rf_raddr,
    output logic [W-1:0]  o_rf_rdata,
    output logic          o_au_start,
    output logic [W-1:0]  o_au_R,
    output logic [W-1:0]  o_au_S,
    output logic [W-1:0]  o_au_Iimm,
    output logic [1:0]    o_au_op_sel,
    output logic [1:0]    o_au_mul_y_sel,
    input  logic [W-1:0]  i_au_result,
    input  logic          i_au_done,
    input  logic          i_au_busy,
    output logic          o_seq_busy,
    output logic          o_wb_pulse,
    output logic          o_err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Magnitude of +1.0 in the fixed-point format.
    localparam logic [W-2:0] ONE_MAG = {{(W - 2 - FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_instr;
    logic [W-1:0]  r_au_R;
    logic [W-1:0]  r_au_S;
    logic [W-1:0]  r_rdata;
    logic          r_wb;
    logic [W-1:0]  r_rf [NREG];

    logic          w_accept;
    logic          w_wb;
    logic          w_wd_expire;
    logic [1:0]    w_op;
    logic [1:0]    w_muly;
    logic [1:0]    w_imm;
    logic [AW-1:0] w_dst;
    logic [AW-1:0] w_srca;
    logic [AW-1:0] w_srcb;
    logic [W-1:0]  w_rf_a;
    logic [W-1:0]  w_rf_b;
    logic [W-1:0]  w_iimm;
    logic          w_unused;

    assign w_op   = r_instr[IW-1 -: 2];
    assign w_muly = r_instr[IW-3 -: 2];
    assign w_imm  = r_instr[IW-5 -: 2];
    assign w_dst  = r_instr[3*AW-1 -: AW];
    assign w_srca = r_instr[2*AW-1 -: AW];
    assign w_srcb = r_instr[AW-1:0];

    assign w_rf_a = r_rf[w_srca];
    assign w_rf_b = r_rf[w_srcb];

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        o_instr_ready = 1'b0;
        o_au_start    = 1'b0;
        w_wb          = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_au_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (i_au_done) begin
                    // Reset must not let an in-flight result reach the register file.
                    w_wb   = ~i_rst;
                    w_next = S_IDLE;
                end else if (w_wd_expire) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept   = i_instr_valid & o_instr_ready;
    assign o_seq_busy = (r_state != S_IDLE);

    // ------------------------------------------------------- operands / controls
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr <= '0;
            r_au_R  <= '0;
            r_au_S  <= '0;
            r_wb    <= 1'b0;
        end else begin
            r_wb <= w_wb;
            if (w_accept) begin
                r_instr <= i_instr;
            end
            if (r_state == S_ISSUE) begin
                r_au_R <= w_rf_a;
                r_au_S <= w_rf_b;
            end
        end
    end

    // Operands come straight from the register file during ISSUE so that a write
    // committed on the accept edge is still seen; the captured copy holds them in WAIT.
    assign o_au_R = (r_state == S_ISSUE) ? w_rf_a : r_au_R;
    assign o_au_S = (r_state == S_ISSUE) ? w_rf_b : r_au_S;

    always_comb begin
        w_iimm = '0;
        case (w_imm)
            2'b01:   w_iimm = {1'b0, ONE_MAG};
            2'b10:   w_iimm = {1'b1, ONE_MAG};
            default: w_iimm = '0;
        endcase
    end

    assign o_au_Iimm      = w_iimm;
    assign o_au_op_sel    = w_op;
    assign o_au_mul_y_sel = w_muly;
    assign o_wb_pulse     = r_wb;

    // -------------------------------------------------------- register file
    // On an address collision the AU writeback takes precedence over the host.
    always_ff @(posedge i_clk) begin
        if (w_wb) begin
            r_rf[w_dst] <= i_au_result;
        end
        if (i_rf_we && !(w_wb && (i_rf_waddr == w_dst))) begin
            r_rf[i_rf_waddr] <= i_rf_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_rf[i_rf_raddr];
        end
    end

    assign o_rf_rdata = r_rdata;

    // ------------------------------------------------------------ watchdog
`ifdef AUSEQ_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_wd;
    logic          r_err;

    assign w_wd_expire = (r_wd == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT && !i_au_done) begin
                r_wd <= r_wd + 1'b1;
                if (w_wd_expire) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_err_timeout = r_err;
    assign w_unused      = i_au_busy;
`else
    assign w_wd_expire   = 1'b0;
    assign o_err_timeout = 1'b0;
    assign w_unused      = i_au_busy ^ (^8'(TIMEOUT));
`endif

endmodule

// File: tb/tb_au_sequencer.sv
// Bench for au_sequencer: behavioural AU responder plus operand and writeback scoreboards.
module tb_au_sequencer;

    localparam int W = 24, FRAC = 14, NREG = 16, AW = 4, IW = 18, TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [AW-1:0] rf_raddr = '0;
    logic [W-1:0]  rf_rdata;
    logic          au_start;
    logic [W-1:0]  au_R, au_S, au_Iimm;
    logic [1:0]    au_op_sel, au_mul_y_sel;
    logic [W-1:0]  au_result;
    logic          au_done;
    logic          au_busy;
    logic          seq_busy, wb_pulse, err_timeout;

    always #5 clk = ~clk;

    au_sequencer #(.W(W), .FRAC(FRAC), .NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_instr_valid(instr_valid), .o_instr_ready(instr_ready), .i_instr(instr),
        .i_rf_we(rf_we), .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata),
        .i_rf_raddr(rf_raddr), .o_rf_rdata(rf_rdata),
        .o_au_start(au_start), .o_au_R(au_R), .o_au_S(au_S), .o_au_Iimm(au_Iimm),
        .o_au_op_sel(au_op_sel), .o_au_mul_y_sel(au_mul_y_sel),
        .i_au_result(au_result), .i_au_done(au_done), .i_au_busy(au_busy),
        .o_seq_busy(seq_busy), .o_wb_pulse(wb_pulse), .o_err_timeout(err_timeout)
    );

    // ------------------------------------------------------------ AU model
    logic         m_done = 1'b0, m_busy = 1'b0, mute = 1'b0, inj_done = 1'b0;
    logic [W-1:0] m_res = '0;
    int           m_cnt = 0;

    assign au_done   = m_done | inj_done;
    assign au_busy   = m_busy;
    assign au_result = m_res;

    function automatic longint sm2i(input logic [W-1:0] v);
        longint mag;
        mag = longint'(v[W-2:0]);
        return v[W-1] ? -mag : mag;
    endfunction

    function automatic logic [W-1:0] i2sm(input longint x);
        if (x < 0) return {1'b1, (W-1)'(-x)};
        return {1'b0, (W-1)'(x)};
    endfunction

    function automatic logic [W-1:0] au_calc(input logic [1:0] op, input logic [1:0] muly,
                                             input logic [W-1:0] r, input logic [W-1:0] s,
                                             input logic [W-1:0] im);
        longint a, b, y, res;
        a = sm2i(r);
        b = sm2i(s);
        y = (muly == 2'b01) ? sm2i(im) : b;
        case (op)
            2'b00:   res = a + b;
            2'b01:   res = a - b;
            2'b10:   res = (a * y) / (longint'(1) << FRAC);
            default: res = (b != 0) ? (a * (longint'(1) << FRAC)) / b : 0;
        endcase
        return i2sm(res);
    endfunction

    // ADD/SUB/MUL answer two cycles after start; DIV takes two more, with busy raised.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (au_start) begin
            m_cnt  <= (au_op_sel == 2'b11) ? 3 : 1;
            m_busy <= (au_op_sel == 2'b11);
            m_res  <= au_calc(au_op_sel, au_mul_y_sel, au_R, au_S, au_Iimm);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= ~mute;
                m_busy <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------- scoreboard
    typedef struct packed {logic [AW-1:0] addr; logic [W-1:0] val;} rd_t;
    typedef struct packed {logic [W-1:0] r, s, im; logic [1:0] op, muly;} op_t;

    rd_t exp_q[$];
    rd_t rd_q[$];
    op_t op_q[$];
    rd_t rd_cur;
    bit  rd_pend = 1'b0;
    int  n_tests = 0, n_fail = 0, wb_cnt = 0, start_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        op_t e;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                chk($sformatf("rf_r%0d", rd_cur.addr), 32'(rf_rdata), 32'(rd_cur.val));
                rd_pend = 1'b0;
            end
            if (au_start) begin
                start_cnt++;
                if (op_q.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    e = op_q.pop_front();
                    chk("op_R", 32'(au_R), 32'(e.r));
                    chk("op_S", 32'(au_S), 32'(e.s));
                    chk("op_Iimm", 32'(au_Iimm), 32'(e.im));
                    chk("op_sel", 32'(au_op_sel), 32'(e.op));
                    chk("op_muly", 32'(au_mul_y_sel), 32'(e.muly));
                end
            end
            if (wb_pulse) begin
                wb_cnt++;
                if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
                else rd_q.push_back(exp_q.pop_front());
            end
            if (!rd_pend && rd_q.size() > 0) begin
                rd_cur   = rd_q.pop_front();
                rf_raddr = rd_cur.addr;
                rd_pend  = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------ helpers
    function automatic logic [IW-1:0] mk(input logic [1:0] op, input logic [1:0] muly,
                                         input logic [1:0] imm, input logic [AW-1:0] dst,
                                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        return {op, muly, imm, dst, a, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hw(input logic [AW-1:0] a, input logic [W-1:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        @(negedge clk);
        rf_we = 1'b0;
    endtask

    task automatic exp_op(input logic [W-1:0] r, input logic [W-1:0] s, input logic [W-1:0] im,
                          input logic [1:0] op, input logic [1:0] muly);
        op_q.push_back('{r: r, s: s, im: im, op: op, muly: muly});
    endtask

    task automatic exp_wb(input logic [AW-1:0] a, input logic [W-1:0] v);
        exp_q.push_back('{addr: a, val: v});
    endtask

    // Returns at the negedge of the ISSUE cycle.
    task automatic issue(input logic [IW-1:0] ins, input bit hold, output int waited);
        instr_valid = 1'b1;
        instr       = ins;
        waited      = 0;
        while (!instr_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("idle_timeout", 0, 1);
    endtask

    // --------------------------------------------------------------- main
    initial begin
        int w, w2, w0, s0, n;
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        fork monitor(); join_none
        tick(3);

        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_start", 32'(au_start), 0);
        chk("rst_R", 32'(au_R), 0);
        chk("rst_S", 32'(au_S), 0);
        chk("rst_Iimm", 32'(au_Iimm), 0);
        chk("rst_op", 32'(au_op_sel), 0);
        chk("rst_muly", 32'(au_mul_y_sel), 0);
        chk("rst_rdata", 32'(rf_rdata), 0);
        chk("rst_busy", 32'(seq_busy), 0);
        chk("rst_wb", 32'(wb_pulse), 0);
        chk("rst_err", 32'(err_timeout), 0);
        rst = 1'b0;
        tick(1);

        hw(1, 24'h008000); hw(2, 24'h806000); hw(5, 24'h004000); hw(6, 24'h008000);
        rd_q.push_back('{addr: 4'd2, val: 24'h806000});
        tick(3);

        // ADD r3 = r1 + r2 with cycle-exact latency
        exp_op(24'h008000, 24'h806000, 24'h0, 2'b00, 2'b00);
        exp_wb(3, 24'h002000);
        w0 = wb_cnt;
        issue(mk(2'b00, 2'b00, 2'b00, 3, 1, 2), 1'b0, w);
        chk("add_start_c1", 32'(au_start), 1);
        chk("add_busy_c1", 32'(seq_busy), 1);
        tick(1);
        chk("add_start_c2", 32'(au_start), 0);
        chk("add_hold_R_c2", 32'(au_R), 32'h008000);
        tick(1);
        chk("add_ready_c3", 32'(instr_ready), 0);
        tick(1);
        chk("add_ready_c4", 32'(instr_ready), 1);
        chk("add_wb_c4", 32'(wb_pulse), 1);
        tick(3);
        chk("add_wb_once", 32'(wb_cnt - w0), 1);

        // MUL r4 = r1 * (-1.0 immediate)
        exp_op(24'h008000, 24'h806000, 24'h804000, 2'b10, 2'b01);
        exp_wb(4, 24'h808000);
        issue(mk(2'b10, 2'b01, 2'b10, 4, 1, 2), 1'b0, w);
        wait_idle();
        tick(3);

        // DIV r7 = r5 / r6, host writes r10 in the writeback cycle
        exp_op(24'h004000, 24'h008000, 24'h0, 2'b11, 2'b00);
        exp_wb(7, 24'h002000);
        s0 = start_cnt;
        issue(mk(2'b11, 2'b00, 2'b00, 7, 5, 6), 1'b0, w);
        n = 1;
        while (!instr_ready && n < 50) begin
            if (au_done) begin
                rf_we = 1'b1; rf_waddr = 10; rf_wdata = 24'h000123;
            end else rf_we = 1'b0;
            @(negedge clk);
            n++;
        end
        rf_we = 1'b0;
        chk("div_ready_cycle", 32'(n), 6);
        tick(3);
        chk("div_one_start", 32'(start_cnt - s0), 1);
        rd_q.push_back('{addr: 4'd10, val: 24'h000123});
        tick(4);

        // Back-to-back dependency: r8 = r1 + r1, r9 = r8 - r1
        exp_op(24'h008000, 24'h008000, 24'h0, 2'b00, 2'b00);
        exp_op(24'h010000, 24'h008000, 24'h0, 2'b01, 2'b00);
        exp_wb(8, 24'h010000);
        exp_wb(9, 24'h008000);
        issue(mk(2'b00, 2'b00, 2'b00, 8, 1, 1), 1'b1, w);
        instr = mk(2'b01, 2'b00, 2'b00, 9, 8, 1);
        issue(instr, 1'b0, w2);
        chk("b2b_accept_cycle", 32'(w2 + 1), 4);
        wait_idle();
        tick(4);

        // Collision: host write to r3 in the writeback cycle is dropped
        exp_op(24'h008000, 24'h008000, 24'h0, 2'b00, 2'b00);
        exp_wb(3, 24'h010000);
        issue(mk(2'b00, 2'b00, 2'b00, 3, 1, 1), 1'b0, w);
        n = 0;
        while (!au_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("coll_done_seen", 32'(au_done), 1);
        rf_we = 1'b1; rf_waddr = 3; rf_wdata = 24'h00FFFF;
        @(negedge clk);
        rf_we = 1'b0;
        wait_idle();
        tick(4);

        // Stale done while idle
        w0 = wb_cnt;
        inj_done = 1'b1;
        tick(1);
        inj_done = 1'b0;
        tick(3);
        chk("idle_done_wb", 32'(wb_cnt - w0), 0);
        chk("idle_done_busy", 32'(seq_busy), 0);

        // Reset mid-WAIT, then a late done
        hw(11, 24'h000555);
        mute = 1'b1;
        exp_op(24'h008000, 24'h806000, 24'h0, 2'b00, 2'b00);
        w0 = wb_cnt;
        issue(mk(2'b00, 2'b00, 2'b00, 11, 1, 2), 1'b0, w);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstw_busy", 32'(seq_busy), 0);
        chk("rstw_ready", 32'(instr_ready), 1);
        inj_done = 1'b1;
        tick(1);
        inj_done = 1'b0;
        tick(3);
        chk("rstw_no_wb", 32'(wb_cnt - w0), 0);
        chk("rstw_err", 32'(err_timeout), 0);
        rd_q.push_back('{addr: 4'd11, val: 24'h000555});
        mute = 1'b0;
        tick(4);

`ifdef AUSEQ_TIMEOUT_EN
        // Watchdog: no done at all
        hw(12, 24'h000777);
        mute = 1'b1;
        exp_op(24'h008000, 24'h806000, 24'h0, 2'b00, 2'b00);
        w0 = wb_cnt;
        issue(mk(2'b00, 2'b00, 2'b00, 12, 1, 2), 1'b0, w);
        n = 0;
        while (!err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 65);
        chk("to_idle", 32'(seq_busy), 0);
        tick(3);
        chk("to_no_wb", 32'(wb_cnt - w0), 0);
        rd_q.push_back('{addr: 4'd12, val: 24'h000777});
        mute = 1'b0;
        tick(3);
        exp_op(24'h008000, 24'h806000, 24'h0, 2'b00, 2'b00);
        exp_wb(13, 24'h002000);
        issue(mk(2'b00, 2'b00, 2'b00, 13, 1, 2), 1'b0, w);
        wait_idle();
        tick(3);
        chk("to_sticky", 32'(err_timeout), 1);
`endif

        n = 0;
        while ((rd_q.size() > 0 || rd_pend) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("exp_q_left", 32'(exp_q.size()), 0);
        chk("op_q_left", 32'(op_q.size()), 0);
        chk("rd_q_left", 32'(rd_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/au_sequencer.md
Name: au_sequencer

Overview:
- Initiator and issuer for the sign-magnitude arithmetic unit `au`.
- Accepts micro-op instructions over a valid/ready port and reads operands from an internal register file.
- Drives `au_start`, the operands and the op controls, waits for `au_done`, then writes `au_result` back into the register file.
- Sits between the Kalman-filter step controller and the AU; serialises all arithmetic for predict/update steps.

Parameters:
- W, 24, word width (sign-magnitude: bit W-1 = sign, W-2:0 = magnitude).
- FRAC, 14, fractional bits; defines the +1.0 immediate as magnitude 1<<FRAC.
- NREG, 16, register-file depth (power of two); AW = log2(NREG).
- TIMEOUT, 64, max cycles in WAIT before error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- instr  in  6+3*AW  {op[1:0], muly[1:0], imm[1:0], dst, srca, srcb}, MSB first
- rf_we  in  1  host register write
- rf_waddr  in  AW  host write address
- rf_wdata  in  W  host write data
- rf_raddr  in  AW  host read address
- rf_rdata  out  W  registered read data (1-cycle latency)
- au_start  out  1  one-cycle start pulse to AU
- au_R, au_S, au_Iimm  out  W  operands
- au_op_sel  out  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- au_mul_y_sel  out  2  00 S, 01 Iimm, 10 inv(S), 11 reserved
- au_result  in  W  AU result
- au_done  in  1  AU result-valid pulse
- au_busy  in  1  AU reciprocal busy (status only)
- seq_busy  out  1  not IDLE
- wb_pulse  out  1  one-cycle pulse on writeback
- err_timeout  out  1  sticky watchdog error; cleared only by rst

Behaviour:
- Reset: state=IDLE, instr_ready=1, au_start=0, au_R/au_S/au_Iimm=0, au_op_sel=0, au_mul_y_sel=0, rf_rdata=0, seq_busy=0, wb_pulse=0, err_timeout=0. Register-file contents are not reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr and go to ISSUE.
  - au_done is ignored in IDLE, so a stale pulse from the resetless AU has no effect.
- ISSUE (1 cycle):
  - Drive au_start=1.
  - au_R=rf[srca], au_S=rf[srcb]. Reads here see any writeback committed on an earlier edge.
  - au_Iimm from imm: 00 → 0, 01 → {0, 1<<FRAC}, 10 → {1, 1<<FRAC}, 11 → 0.
  - au_op_sel=op, au_mul_y_sel=muly.
  - Go to WAIT and clear the watchdog counter.
- WAIT:
  - Operands and controls are held stable; au_start=0; instr_ready=0.
  - On au_done: rf[dst] <= au_result on that edge, wb_pulse=1 next cycle, go to IDLE.
  - If the counter reaches TIMEOUT-1 with no done: set err_timeout, go to IDLE, no writeback.
- Latency: instruction accepted at edge 0 → au_start high cycle 1 → AU done at cycle 3 for ADD/SUB/MUL → rf updated and instr_ready high at cycle 4. DIV takes AU latency plus 2.
- Host write collides with a writeback to the same address in the same cycle: writeback wins; host data is dropped. Different addresses: both commit.
- rf_rdata <= rf[rf_raddr] every cycle; a write to the same address shows on the next read.
- dst may equal srca/srcb; reads happen in ISSUE, before writeback.
- rst mid-WAIT: return to IDLE, discard the in-flight op, and ignore any later au_done.
- No arithmetic in this block; all values pass through unmodified.

Optional Feature:
- Macro: AUSEQ_TIMEOUT_EN.
- Defined: watchdog counter and err_timeout active as described.
- Undefined: no counter; WAIT exits only on au_done; err_timeout is tied to 0.

Test Plan:
- ADD: host writes r1=0x008000 (2.0), r2=0x806000 (-1.5); issue op=00 dst=3 srca=1 srcb=2 → au_start in the cycle after accept, then r3=0x002000 (0.5) and wb_pulse once.
- MUL by immediate: op=10 muly=01 imm=10, srca=1 (2.0) → au_Iimm=0x804000; r4=0x808000 (-2.0).
- DIV: r5=0x004000, r6=0x008000, op=11 dst=7 → instr_ready stays 0 through all AU busy cycles; r7=0x002000; exactly one au_start.
- Back-to-back dependency:
  - Stimulus: hold instr_valid; issue ADD r8=r1+r1, then SUB r9=r8-r1.
  - Required: second accepted cycle 4; r9=0x008000.
- Collision: host rf_we to r3 with 0x00FFFF in the same cycle as writeback to r3 → r3 holds the AU result.
- Timeout and reset (TIMEOUT=64, macro defined):
  - With au_done held 0: err_timeout set 64 cycles after ISSUE, FSM returns to IDLE, no writeback.
  - rst mid-WAIT followed by an au_done pulse: no writeback, err_timeout=0.
